// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming convolution layer.
package conv_pkg;

    typedef enum logic {
        ACT_RELU = 1'b0,
        ACT_NONE = 1'b1
    } act_e;

    // Exact accumulator width: product width plus growth for K*K terms.
    function automatic int acc_width(input int dw, input int kw, input int k);
        return dw + kw + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One row of pixel history, indexed by column; read-before-write on a shared address.
module conv_line_buffer
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/conv_stream_layer.sv
// Streaming KxK valid-padding convolution over a raster image, NUM_FILTERS outputs per window.
module conv_stream_layer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KDATA_WIDTH = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMGCOL      = 28,
    parameter int IMGROW      = 28,
    parameter int NUM_FILTERS = 4,
    parameter     ACTIVATION  = "RELU",
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, KDATA_WIDTH, KERNEL_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [KDATA_WIDTH-1:0] kernel [NUM_FILTERS][KERNEL_SIZE][KERNEL_SIZE],
    input  logic signed [DATA_WIDTH-1:0]  pix_in,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic signed [ACC_WIDTH-1:0]   conv_out [NUM_FILTERS],
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          layer_done_out
);

    localparam int   K        = KERNEL_SIZE;
    localparam int   CW       = (IMGCOL > 1) ? $clog2(IMGCOL) : 1;
    localparam int   RW       = (IMGROW > 1) ? $clog2(IMGROW) : 1;
    localparam act_e ACT_MODE = (ACTIVATION == "NONE") ? ACT_NONE : ACT_RELU;

    logic                          accept;
    logic                          produce;
    logic                          at_last_col;
    logic                          at_last_row;
    logic                          last_pending;
    logic [CW-1:0]                 col;
    logic [RW-1:0]                 row;
    logic [DATA_WIDTH-1:0]         lb_chain [K];
    logic signed [DATA_WIDTH-1:0]  win      [K][K];
    logic signed [DATA_WIDTH-1:0]  win_next [K][K];
    logic signed [KDATA_WIDTH-1:0] kernel_q [NUM_FILTERS][K][K];
    logic signed [ACC_WIDTH-1:0]   sum      [NUM_FILTERS];

    assign pix_ready   = !out_valid || out_ready;
    assign accept      = pix_valid && pix_ready;
    assign at_last_col = (col == CW'(IMGCOL - 1));
    assign at_last_row = (row == RW'(IMGROW - 1));
    assign produce     = (col >= CW'(K - 1)) && (row >= RW'(K - 1));

    // lb_chain[0] is the live pixel; lb_chain[g+1] is the same column g+1 rows earlier.
    assign lb_chain[0] = pix_in;

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        conv_line_buffer #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (IMGCOL)
        ) u_line_buffer (
            .clk   (clk),
            .wr_en (accept),
            .addr  (col),
            .din   (lb_chain[g]),
            .dout  (lb_chain[g+1])
        );
    end

    always_comb begin
        win_next = win;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K - 1; j++) begin
                win_next[i][j] = win[i][j+1];
            end
            win_next[i][K-1] = lb_chain[K-1-i];
        end
    end

    // Sum over the window as it will look after this pixel shifts in.
    always_comb begin
        for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
            sum[f] = '0;
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K; j++) begin
                    sum[f] = sum[f] + ACC_WIDTH'(win_next[i][j]) * ACC_WIDTH'(kernel_q[f][i][j]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
                for (int unsigned i = 0; i < K; i++) begin
                    for (int unsigned j = 0; j < K; j++) begin
                        kernel_q[f][i][j] <= '0;
                    end
                end
            end
        end else if (accept) begin
            if (col == '0 && row == '0) begin
                kernel_q <= kernel;
            end
            if (at_last_col) begin
                col <= '0;
                row <= at_last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            last_pending   <= 1'b0;
            layer_done_out <= 1'b0;
            for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
                conv_out[f] <= '0;
            end
        end else begin
            layer_done_out <= out_valid && out_ready && last_pending;
            if (accept && produce) begin
                out_valid    <= 1'b1;
                last_pending <= at_last_col && at_last_row;
                for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
                    conv_out[f] <= (ACT_MODE == ACT_RELU && sum[f] < 0) ? '0 : sum[f];
                end
            end else if (out_ready) begin
                out_valid    <= 1'b0;
                last_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_layer.sv
// Self-checking bench for conv_stream_layer: direct 2-D convolution model, RELU and NONE instances side by side.
module tb_conv_stream_layer;

    localparam int K  = 3;
    localparam int N  = 28;
    localparam int F  = 4;
    localparam int NO = (N - K + 1) * (N - K + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [7:0]  kernel [F][K][K];
    logic signed [7:0]  pix_in = '0;
    logic               pix_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic               pix_ready, pix_ready_n;
    logic               out_valid, out_valid_n;
    logic               done_r, done_n;
    logic signed [19:0] out_r [F];
    logic signed [19:0] out_n [F];

    int n_tests = 0;
    int n_fail  = 0;
    int expq[$];
    bit lastq[$];
    int hs_total = 0;
    int done_cnt = 0;
    bit done_next = 1'b0;
    bit gaps = 1'b0;
    int last_r [F];
    int last_n [F];

    always #5 clk = ~clk;

    conv_stream_layer #(
        .DATA_WIDTH(8), .KDATA_WIDTH(8), .KERNEL_SIZE(K), .IMGCOL(N), .IMGROW(N),
        .NUM_FILTERS(F), .ACTIVATION("RELU")
    ) u_dut (
        .clk(clk), .rst(rst), .kernel(kernel), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .conv_out(out_r), .out_valid(out_valid),
        .out_ready(out_ready), .layer_done_out(done_r)
    );

    conv_stream_layer #(
        .DATA_WIDTH(8), .KDATA_WIDTH(8), .KERNEL_SIZE(K), .IMGCOL(N), .IMGROW(N),
        .NUM_FILTERS(F), .ACTIVATION("NONE")
    ) u_dut_none (
        .clk(clk), .rst(rst), .kernel(kernel), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready_n), .conv_out(out_n), .out_valid(out_valid_n),
        .out_ready(out_ready), .layer_done_out(done_n)
    );

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int pix_val(input int pat, input int r, input int c);
        case (pat)
            0:       return 1;
            1:       return -128;
            2:       return ((r * 7 + c * 3) % 23) - 11;
            default: return ((r * c + 5) % 255) - 127;
        endcase
    endfunction

    function automatic int kern_val(input int pat, input int f, input int i, input int j);
        case (pat)
            0:       return 1;
            1:       return (f == 0) ? -1 : 1;
            2:       return -128;
            3:       return (((f * 9 + i * 3 + j) * 5) % 15) - 7;
            default: return ((f + i * 2 + j * 3) % 7) - 3;
        endcase
    endfunction

    task automatic set_kernel(input int pat);
        for (int f = 0; f < F; f++)
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    kernel[f][i][j] = 8'(kern_val(pat, f, i, j));
    endtask

    // Full-frame expectation from the image pattern and the kernel present at frame start.
    task automatic model_frame(input int pat);
        int kk [F][K][K];
        int s;
        for (int f = 0; f < F; f++)
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    kk[f][i][j] = int'(kernel[f][i][j]);
        for (int r = 0; r <= N - K; r++) begin
            for (int c = 0; c <= N - K; c++) begin
                for (int f = 0; f < F; f++) begin
                    s = 0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            s += pix_val(pat, r + i, c + j) * kk[f][i][j];
                    expq.push_back(s);
                end
                lastq.push_back(r == N - K && c == N - K);
            end
        end
    endtask

    task automatic send_frame(input int pat, input int npix, input int kchange_at, input int kchange_pat);
        bit ok;
        int waited;
        model_frame(pat);
        for (int idx = 0; idx < npix; idx++) begin
            if (idx == kchange_at) set_kernel(kchange_pat);
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    pix_valid = 1'b0;
                    pix_in    = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            pix_in    = 8'(pix_val(pat, idx / N, idx % N));
            pix_valid = 1'b1;
            waited    = 0;
            ok        = 1'b0;
            while (!ok && waited < 200) begin
                @(negedge clk);
                ok = pix_ready;
                @(posedge clk); #1;
                waited++;
            end
            if (!ok) begin
                check("pix_accept_timeout", 0, 1);
                break;
            end
        end
        pix_valid = 1'b0;
        pix_in    = 8'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while ((expq.size() != 0 || out_valid) && w < 3000) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_timeout", longint'(w < 3000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done_r, 0);
        check("rst_pix_ready", pix_ready, 1);
        for (int f = 0; f < F; f++) begin
            check("rst_conv_out", out_r[f], 0);
            check("rst_conv_out_none", out_n[f], 0);
        end
        expq.delete();
        lastq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            done_next = 1'b0;
        end else begin
            check("layer_done", done_r, longint'(done_next));
            check("layer_done_none", done_n, longint'(done_next));
            check("out_valid_match", out_valid_n, out_valid);
            check("pix_ready_match", pix_ready_n, pix_ready);
            if (done_r) done_cnt++;
            done_next = 1'b0;
            if (out_valid && out_ready) begin
                if (expq.size() < F) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    for (int f = 0; f < F; f++) begin
                        int e;
                        e = expq.pop_front();
                        check("conv_out_relu", out_r[f], (e < 0) ? 0 : e);
                        check("conv_out_none", out_n[f], e);
                        last_r[f] = int'(out_r[f]);
                        last_n[f] = int'(out_n[f]);
                    end
                    done_next = lastq.pop_front();
                    hs_total++;
                end
            end
        end
    end

    initial begin
        int h0, d0;
        set_kernel(0);
        #2;
        do_reset();

        h0 = hs_total; d0 = done_cnt;
        send_frame(0, N * N, -1, 0);
        drain();
        check("ones_handshakes", hs_total - h0, NO);
        check("ones_done_pulses", done_cnt - d0, 1);
        for (int f = 0; f < F; f++) begin
            check("ones_relu_value", last_r[f], 9);
            check("ones_none_value", last_n[f], 9);
        end

        set_kernel(1);
        send_frame(0, N * N, -1, 0);
        drain();
        check("neg_relu_f0", last_r[0], 0);
        check("neg_none_f0", last_n[0], -9);
        check("neg_relu_f1", last_r[1], 9);

        set_kernel(2);
        send_frame(1, N * N, -1, 0);
        drain();
        check("max_mag_relu", last_r[0], 147456);
        check("max_mag_none", last_n[3], 147456);

        h0 = hs_total; d0 = done_cnt;
        gaps = 1'b1;
        set_kernel(3);
        send_frame(2, N * N, -1, 0);
        drain();
        gaps = 1'b0;
        check("gaps_handshakes", hs_total - h0, NO);
        check("gaps_done_pulses", done_cnt - d0, 1);

        h0 = hs_total; d0 = done_cnt;
        set_kernel(3);
        send_frame(3, N * N, 300, 4);
        send_frame(2, N * N, -1, 0);
        drain();
        check("b2b_handshakes", hs_total - h0, 2 * NO);
        check("b2b_done_pulses", done_cnt - d0, 2);

        send_frame(2, 10 * N + 5, -1, 0);
        do_reset();
        h0 = hs_total; d0 = done_cnt;
        send_frame(3, N * N, -1, 0);
        drain();
        check("post_rst_handshakes", hs_total - h0, NO);
        check("post_rst_done_pulses", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_stream_layer.md
CONV_STREAM_LAYER -- requirements
Module: conv_stream_layer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width, signed two's complement.
REQ-002 SHALL have parameter KDATA_WIDTH, default 8: kernel coefficient width, signed two's complement.
REQ-003 SHALL have parameter KERNEL_SIZE, default 3: square kernel edge K; legal range 2..7.
REQ-004 SHALL have parameter IMGCOL, default 28: pixels per row.
REQ-005 SHALL have parameter IMGROW, default 28: rows per frame.
REQ-006 SHALL have parameter NUM_FILTERS, default 4: output channels F computed in parallel per window.
REQ-007 SHALL have parameter ACTIVATION, default "RELU": "RELU" or "NONE".
REQ-008 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-009 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have port kernel, input, [F][K][K] x KDATA_WIDTH: filter coefficients.
REQ-011 SHALL have port pix_in, input, DATA_WIDTH: raster-order pixel, row-major.
REQ-012 SHALL have port pix_valid, input, 1: pix_in is valid.
REQ-013 SHALL have port pix_ready, output, 1: block accepts pix_in this cycle.
REQ-014 SHALL have port conv_out, output, [F] x ACC_WIDTH: one result per filter, signed.
REQ-015 SHALL have port out_valid, output, 1: conv_out is valid.
REQ-016 SHALL have port out_ready, input, 1: downstream accepts conv_out.
REQ-017 SHALL have port layer_done_out, output, 1: one-cycle pulse at frame completion.

Function
REQ-018 SHALL define ACC_WIDTH = DATA_WIDTH+KDATA_WIDTH+clog2(K*K); all sums are exact, with no overflow or saturation.
REQ-019 SHALL accept a pixel only on a cycle with pix_valid && pix_ready.
REQ-020 SHALL drive pix_ready = !out_valid || out_ready, giving a single-stage skid-free output register.
REQ-021 SHALL store the previous K-1 rows in line buffers of IMGCOL entries and hold a KxK window register shifted per accepted pixel.
REQ-022 SHALL track col (0..IMGCOL-1) and row (0..IMGROW-1); col SHALL wrap to 0 and row SHALL increment on the last column; row SHALL wrap to 0 after the last pixel of a frame.
REQ-023 SHALL produce an output only when the accepted pixel has col>=K-1 and row>=K-1 (stride 1, valid padding), giving (IMGROW-K+1)*(IMGCOL-K+1) outputs per frame.
REQ-024 SHALL compute, for each filter f, conv_out[f] = sum over i,j of window[i][j]*kernel_latched[f][i][j], with all terms signed.
REQ-025 SHALL apply ACTIVATION "RELU" as negative results replaced by 0; "NONE" SHALL pass results unchanged.
REQ-026 SHALL assert out_valid on the cycle after the accepting edge (latency 1), holding conv_out stable until out_ready.
REQ-027 SHALL latch kernel into an internal copy when the pixel at row 0, col 0 is accepted; kernel changes mid-frame SHALL have no effect until the next frame.
REQ-028 SHALL pulse layer_done_out for exactly one cycle, on the cycle after the frame's last output handshake completes.
REQ-029 SHALL accept the first pixel of the next frame in the same cycle as the last output handshake, with no bubble required.
REQ-030 SHALL ignore pix_in entirely when pix_valid is low, with no counter or window change.

Reset
REQ-031 SHALL, on rst, asynchronously clear out_valid, layer_done_out, col, row, conv_out (to 0) and the latched kernel (to 0).
REQ-032 SHALL leave line-buffer contents unreset; stale data SHALL never reach an output because of REQ-023.
REQ-033 SHALL treat the first accepted pixel after a mid-frame reset as row 0, col 0 of a new frame.

Structure
REQ-034 SHALL take the activation enum and ACC_WIDTH helper function from shared package conv_pkg.
REQ-035 SHALL implement one line-buffer row as sub-module conv_line_buffer, instantiated K-1 times.

Verification
REQ-036 SHALL cover: 28x28 image all 1, all kernels all 1, K=3 -> 676 outputs, each 9 on every filter, one layer_done_out pulse.
REQ-037 SHALL cover: pixels all 1, filter 0 all -1, both modes -> RELU gives 0; NONE gives -9.
REQ-038 SHALL cover: pixels -128, kernel -128, K=3 -> 147456 exactly, with ACC_WIDTH=20.
REQ-039 SHALL cover: random out_ready and pix_valid gaps -> output sequence identical to the uninterrupted run, with no drop or duplicate.
REQ-040 SHALL cover: two back-to-back frames with kernel changed mid-first-frame -> first frame uses the old kernel, second the new; one done pulse per frame.
REQ-041 SHALL cover: rst asserted at row 10 -> outputs go low immediately; the next full frame matches golden.
